metrics_counter_bank: RTL
=========================

Name: metrics_counter_bank

Overview:
Multi-channel performance counter bank; parametrised successor to the single 64-bit cycle counter in the SoC control-register block. Provides NUM_CHANNELS counters, each counting either cycles or multi-bit event increments. Adds global run control, coherent snapshot of all channels, sticky overflow flags and a threshold compare with optional auto-halt. Sits beside the control registers: inputs are driven by ctrl register bytes and accelerator event strobes; outputs feed the register load/readback path.

Parameters:
NUM_CHANNELS, 4, number of independent counters (1..16)
COUNTER_WIDTH, 64, width of each counter in bits (16..64)
INC_WIDTH, 4, width of each per-channel event increment
THRESH_CH, 0, index of the channel compared against threshold
AUTO_STOP, 1, 1 = threshold hit moves FSM to HALTED; 0 = flag only

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  pulse; enter RUN
stop  in  1  pulse; enter IDLE
ch_en  in  NUM_CHANNELS  per-channel count enable (level)
ch_mode  in  NUM_CHANNELS  0 = cycle mode, 1 = event mode
clear  in  NUM_CHANNELS  per-channel pulse; zero counter and its ovf
event_inc  in  NUM_CHANNELS*INC_WIDTH  per-channel increment, unsigned
snapshot  in  1  pulse; capture all live counters
threshold  in  COUNTER_WIDTH  compare value for channel THRESH_CH; 0 = disabled
cnt  out  NUM_CHANNELS*COUNTER_WIDTH  live counter values
snap  out  NUM_CHANNELS*COUNTER_WIDTH  captured values
snap_done  out  1  one-cycle pulse, snap updated
ovf  out  NUM_CHANNELS  sticky overflow flags
thresh_hit  out  1  sticky threshold flag
running  out  1  high in RUN
irq  out  1  registered OR of ovf and thresh_hit

Behaviour:
- Reset (rst_n=0 at edge): cnt, snap, ovf = 0; snap_done, thresh_hit, irq = 0; FSM = IDLE; running = 0.
- FSM states IDLE, RUN, HALTED. IDLE -start-> RUN; RUN -stop-> IDLE; RUN -threshold hit & AUTO_STOP-> HALTED; HALTED -start-> RUN; HALTED -stop-> IDLE. start and stop in the same cycle: stop wins. start into RUN clears thresh_hit in that edge.
- running = (state == RUN), registered with the state.
- Counting only in RUN with ch_en[i]=1: cycle mode adds 1; event mode adds zero-extended event_inc[i] (0 allowed). IDLE/HALTED: counters hold.
- Arithmetic: sum modulo 2^COUNTER_WIDTH; carry-out sets ovf[i] (sticky). Counter updates on the edge, 1-cycle latency from event to cnt.
- clear[i] valid in any state: cnt[i] = 0, ovf[i] = 0; clear beats a same-cycle increment and a same-cycle ovf set.
- snapshot: snap = cnt value present before the edge (pre-increment, pre-clear) for all channels at once; snap_done high the following cycle for exactly one cycle. Back-to-back snapshots each produce a pulse.
- Threshold: evaluated in RUN only, threshold != 0; hit when next value of channel THRESH_CH >= threshold. thresh_hit sets on the same edge the counter reaches it; with AUTO_STOP, state becomes HALTED on that edge, so the counter holds the first value >= threshold. A clear of THRESH_CH does not clear thresh_hit; only start or reset does.
- irq = registered (|ovf | thresh_hit), one cycle behind the flags.
- Reset mid-RUN: all state returns to reset values on that edge regardless of other inputs.

Optional Feature:
METRICS_COUNTER_SATURATE_EN. Defined: a counter whose sum would exceed 2^COUNTER_WIDTH-1 clamps to all-ones and sets ovf[i]; further increments keep it at all-ones. Undefined: wrap-around as specified above. Clear behaviour identical in both builds.

Test Plan:
- Reset then start, ch_en=1, ch_mode=0 on ch0, 10 cycles, stop -> cnt[0]=10, running falls the cycle after stop, cnt holds at 10 for 5 further cycles.
- ch1 event mode, event_inc[1]=3 for 4 cycles in RUN, clear[1] with event_inc=5 on the 5th cycle -> cnt[1]=12 then 0 (clear wins).
- COUNTER_WIDTH=16, ch2 preloaded to 0xFFFE via counting, inc 3 -> wrap build: cnt=0x0001, ovf[2]=1, irq=1 next cycle; saturate build: cnt=0xFFFF, ovf[2]=1.
- threshold=20, AUTO_STOP=1, ch0 cycle mode -> cnt[0]=20, thresh_hit=1 and HALTED same edge, running=0; start -> thresh_hit=0, counting resumes to 21.
- snapshot on the edge ch0 goes 7->8 with clear[0] same cycle -> snap[0]=7, cnt[0]=0, snap_done one cycle later, single cycle wide.
- start+stop asserted together from IDLE -> stays IDLE; rst_n=0 mid-RUN with cnt[0]=50 -> all outputs 0 next edge.

Source files
------------

// File: rtl/metrics_counter_bank.sv
// metrics_counter_bank: multi-channel cycle/event counters with run control, snapshot, overflow and threshold (optional METRICS_COUNTER_SATURATE_EN)
module metrics_counter_bank #(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 64,
  parameter int INC_WIDTH     = 4,
  parameter int THRESH_CH     = 0,
  parameter int AUTO_STOP     = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic                                    stop,
  input  logic [NUM_CHANNELS-1:0]                 ch_en,
  input  logic [NUM_CHANNELS-1:0]                 ch_mode,
  input  logic [NUM_CHANNELS-1:0]                 clear,
  input  logic [NUM_CHANNELS*INC_WIDTH-1:0]       event_inc,
  input  logic                                    snapshot,
  input  logic [COUNTER_WIDTH-1:0]                threshold,
  output logic [NUM_CHANNELS*COUNTER_WIDTH-1:0]   cnt,
  output logic [NUM_CHANNELS*COUNTER_WIDTH-1:0]   snap,
  output logic                                    snap_done,
  output logic [NUM_CHANNELS-1:0]                 ovf,
  output logic                                    thresh_hit,
  output logic                                    running,
  output logic                                    irq
);
  localparam int W = COUNTER_WIDTH;
`ifdef METRICS_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state;
  logic run;
  logic hit;
  logic [W-1:0] cnt_r [NUM_CHANNELS];
  logic [W-1:0] cnt_n [NUM_CHANNELS];
  logic [W-1:0] snap_r [NUM_CHANNELS];
  logic [W:0] sum [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ovf_n;
  assign run = (state == RUN);
  // per-channel next value: clear wins, else add increment when enabled in RUN
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sum[i] = {1'b0, cnt_r[i]} + (ch_mode[i] ? (W+1)'(event_inc[i*INC_WIDTH +: INC_WIDTH]) : (W+1)'(1));
      cnt_n[i] = clear[i] ? '0 : !(run && ch_en[i]) ? cnt_r[i] : (SAT && sum[i][W]) ? '1 : sum[i][W-1:0];
      ovf_n[i] = clear[i] ? 1'b0 : ovf[i] | (run && ch_en[i] && sum[i][W]);
    end
    hit = run && (threshold != '0) && (cnt_n[THRESH_CH] >= threshold);
  end
  // run-control FSM; stop has priority, then auto-halt, then start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      running <= 1'b0;
    end else if (stop) begin
      state <= IDLE;
      running <= 1'b0;
    end else if (run && hit && AUTO_STOP != 0) begin
      state <= HALTED;
      running <= 1'b0;
    end else if (start) begin
      state <= RUN;
      running <= 1'b1;
    end
  end
  // counters, snapshot, sticky flags and interrupt
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt_r[i] <= '0;
        snap_r[i] <= '0;
      end
      ovf <= '0;
      snap_done <= 1'b0;
      thresh_hit <= 1'b0;
      irq <= 1'b0;
    end else begin
      cnt_r <= cnt_n;
      if (snapshot) snap_r <= cnt_r;
      ovf <= ovf_n;
      snap_done <= snapshot;
      thresh_hit <= hit ? 1'b1 : (start && !stop) ? 1'b0 : thresh_hit;
      irq <= (|ovf) | thresh_hit;
    end
  end
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_out
    assign cnt[g*W +: W] = cnt_r[g];
    assign snap[g*W +: W] = snap_r[g];
  end
endmodule
